clock_divider: RTL and testbench

//   Parameterised clock divider for the LED-light design. Derives a slow

---
 rtl/clock_divider.sv | 55 +++++
 tb/tb_clock_divider.sv | 135 +++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// Divides clk by DIV into a 50 % duty clk_sys plus a clk-domain strobe clk_en.
// Odd ratios stretch the high phase by half a clk period with a negedge flop.
module clock_divider #(
  parameter int DIV   = 100_000,
  parameter int CNT_W = $clog2(DIV)
) (
  input  logic clk,
  input  logic resetn,
  output logic clk_sys,
  output logic clk_en
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  // First count of the high phase: N/2 for even, (N+1)/2 for odd.
  localparam logic [CNT_W-1:0] HALF = CNT_W'((DIV + 1) / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             p;

  generate
    if (DIV < 2) begin : g_bad
      $error("clock_divider: DIV must be >= 2");
    end
  endgenerate

  assign cnt_nxt = (cnt == LAST) ? '0 : cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      p   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      p   <= (cnt_nxt >= HALF);
    end
  end

  assign clk_en = (cnt == LAST);

  generate
    if (DIV % 2 == 0) begin : g_even
      assign clk_sys = p;
    end else begin : g_odd
      logic q;
      always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) q <= 1'b0;
        else         q <= p;
      end
      // q trails p by half a cycle, so the OR never sees both move together.
      assign clk_sys = p | q;
    end
  endgenerate

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench: several divider instances share clk/resetn; expected edge
// times of clk_sys and clk_en are derived from the period rules and queued.
module tb_clock_divider;

  localparam int NI = 6;

  logic    clk = 1'b0;
  logic    resetn = 1'b1;
  bit      mon_en = 1'b0;
  int      n_chk = 0;
  int      n_fail = 0;
  longint  p1, ta, tp;
  event    plan_ev, end_ev;

  always #5 clk = ~clk;

  function automatic int div_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 4;
      3: return 5;
      4: return 7;
      default: return 1000;
    endcase
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int     N    = (gi == 0) ? 2 : (gi == 1) ? 3 : (gi == 2) ? 4 :
                              (gi == 3) ? 5 : (gi == 4) ? 7 : 1000;
    localparam longint T    = 10 * N;
    localparam longint HALF = (N + 1) / 2;

    logic   cs, ce;
    longint st[$], et[$];
    bit     sv[$], ev[$];

    clock_divider #(.DIV(N)) dut (
      .clk    (clk),
      .resetn (resetn),
      .clk_sys(cs),
      .clk_en (ce)
    );

    initial begin
      #10;
      check($sformatf("div%0d reset clk_sys", N), longint'(cs), 0);
      check($sformatf("div%0d reset clk_en", N), longint'(ce), 0);
    end

    // Period starts at P1 + m*T; high phase is the second half of the period,
    // strobe is the last clk cycle; reset at ta forces any high output low.
    always @(plan_ev) begin
      longint r, f, er, ef;
      for (longint b = p1; b < ta; b += T) begin
        r  = b + (HALF - 1) * 10;
        f  = b + (N - 1) * 10 + (N % 2) * 5;
        er = b + (N - 2) * 10;
        ef = b + (N - 1) * 10;
        if (r < ta) begin
          st.push_back(r);  sv.push_back(1'b1);
          st.push_back(f < ta ? f : ta); sv.push_back(1'b0);
        end
        if (er < ta) begin
          et.push_back(er); ev.push_back(1'b1);
          et.push_back(ef < ta ? ef : ta); ev.push_back(1'b0);
        end
      end
    end

    always @(cs) if (mon_en) begin
      check($sformatf("div%0d clk_sys edge expected", N), longint'(st.size() > 0), 1);
      if (st.size() > 0) begin
        check($sformatf("div%0d clk_sys edge time", N), $time, st.pop_front());
        check($sformatf("div%0d clk_sys edge value", N), longint'(cs), longint'(sv.pop_front()));
      end
    end

    always @(ce) if (mon_en) begin
      check($sformatf("div%0d clk_en edge expected", N), longint'(et.size() > 0), 1);
      if (et.size() > 0) begin
        check($sformatf("div%0d clk_en edge time", N), $time, et.pop_front());
        check($sformatf("div%0d clk_en edge value", N), longint'(ce), longint'(ev.pop_front()));
      end
    end

    always @(negedge resetn) if (mon_en) begin
      #1;
      check($sformatf("div%0d async reset clk_sys", N), longint'(cs), 0);
      check($sformatf("div%0d async reset clk_en", N), longint'(ce), 0);
    end

    always @(end_ev) begin
      check($sformatf("div%0d clk_sys edges missing", N), st.size(), 0);
      check($sformatf("div%0d clk_en edges missing", N), et.size(), 0);
    end
  end

  initial begin
    int tgt, n, k;
    #1 resetn = 1'b0;
    #11 mon_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      tp = $time;
      if (r == 0) #5;
      else        #($urandom_range(1, 9));
      resetn = 1'b1;
      p1  = tp + 10;
      tgt = $urandom_range(0, NI - 1);
      n   = div_of(tgt);
      k   = 5000 / n + $urandom_range(0, 2);
      // 2 time units after the target's rising edge: inside its high phase.
      ta  = p1 + (longint'(k) * n + (n + 1) / 2 - 1) * 10 + 2;
      ->plan_ev;
      #(ta - $time);
      resetn = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    #50;
    ->end_ev;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
